// File: rtl/tb_align_collector.sv
`default_nettype none
`ifndef BP_WIDTH
`define BP_WIDTH 2
`endif
// ==== tb_align_collector: packs traceback alignment symbols into words via a FWFT FIFO ====
// ==== Rev 1.0 -- optional `ALN_STATS_EN adds sym_count_o ====
module tb_align_collector #(
  parameter int BP_WIDTH   = `BP_WIDTH,
  parameter int WORD_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int SPW       = WORD_WIDTH / BP_WIDTH,
  localparam int NW        = $clog2(SPW + 1)
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic                  tb_valid,
  input  logic [BP_WIDTH-1:0]   alignment_out,
  input  logic                  alignment_valid,
  input  logic                  done,
  output logic [WORD_WIDTH-1:0] word_o,
  output logic [NW-1:0]         word_nsym_o,
  output logic                  word_last_o,
  output logic                  word_valid_o,
  input  logic                  word_ready_i,
  output logic                  overflow_o,
  output logic                  busy_o
`ifdef ALN_STATS_EN
  ,
  output logic [15:0]           sym_count_o
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENT_W = 1 + NW + WORD_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FLUSH   = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic                  r_tb_valid_q;
  logic [WORD_WIDTH-1:0] r_pack;
  logic [WORD_WIDTH-1:0] w_pack_ins;
  logic [NW-1:0]         r_idx;
  logic                  r_full_pend;
  logic [WORD_WIDTH-1:0] r_full_word;
  logic                  r_overflow;

  logic [ENT_W-1:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]        r_count;
  logic                  w_full, w_empty, w_pop;
  logic                  w_push_req, w_push, w_drop;
  logic [ENT_W-1:0]      w_push_data;
  logic                  w_run_start, w_sym_take, w_word_done;

  always_comb begin
    w_run_start = (r_state == S_IDLE) && tb_valid && !r_tb_valid_q;
    w_sym_take  = (r_state == S_COLLECT) && alignment_valid;
    w_word_done = w_sym_take && (r_idx == NW'(SPW - 1));
    w_pack_ins  = r_pack;
    w_pack_ins[int'(r_idx) * BP_WIDTH +: BP_WIDTH] = alignment_out;
  end

  // A completed word waits one cycle in r_full_word; it is pushed or dropped
  // on the following edge, ahead of any terminator.
  always_comb begin
    w_empty     = (r_count == '0);
    w_full      = (r_count == (PTR_W + 1)'(FIFO_DEPTH));
    w_pop       = !w_empty && word_ready_i;
    w_push_req  = r_full_pend || (r_state == S_FLUSH);
    w_push      = w_push_req && (!w_full || w_pop);
    w_drop      = r_full_pend && w_full && !w_pop;
    w_push_data = r_full_pend ? {1'b0, NW'(SPW), r_full_word}
                              : {1'b1, r_idx, r_pack};
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_run_start) w_state_nxt = S_COLLECT;
      S_COLLECT: if (done) w_state_nxt = S_FLUSH;
      S_FLUSH:   if (!r_full_pend && w_push) w_state_nxt = S_DRAIN;
      S_DRAIN:   if (w_empty) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      r_tb_valid_q <= 1'b0;
      r_pack       <= '0;
      r_idx        <= '0;
      r_full_pend  <= 1'b0;
      r_full_word  <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_tb_valid_q <= tb_valid;
      r_full_pend  <= w_word_done;
      if (w_run_start) begin
        r_pack     <= '0;
        r_idx      <= '0;
        r_overflow <= 1'b0;
      end else if (w_sym_take) begin
        if (w_word_done) begin
          r_full_word <= w_pack_ins;
          r_pack      <= '0;
          r_idx       <= '0;
        end else begin
          r_pack <= w_pack_ins;
          r_idx  <= r_idx + 1'b1;
        end
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_comb begin
    {word_last_o, word_nsym_o, word_o} = w_empty ? '0 : r_mem[r_rd_ptr];
    word_valid_o = !w_empty;
    overflow_o   = r_overflow;
    busy_o       = (r_state != S_IDLE);
  end

`ifdef ALN_STATS_EN
  logic [15:0] r_sym_count;

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i)                                    r_sym_count <= '0;
    else if (w_run_start)                            r_sym_count <= '0;
    else if (w_sym_take && r_sym_count != 16'hFFFF)  r_sym_count <= r_sym_count + 1'b1;
  end

  assign sym_count_o = r_sym_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tb_align_collector.sv
`default_nettype none
// Directed bench for tb_align_collector: a queue-level reference model checks every popped word.
module tb_tb_align_collector;
  localparam int BP    = 2;
  localparam int WW    = 32;
  localparam int DEPTH = 4;
  localparam int SPW   = WW / BP;
  localparam int NW    = $clog2(SPW + 1);

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          tb_valid = 1'b0;
  logic [BP-1:0] alignment_out = '0;
  logic          alignment_valid = 1'b0;
  logic          done = 1'b0;
  logic          word_ready_i = 1'b0;
  logic [WW-1:0] word_o;
  logic [NW-1:0] word_nsym_o;
  logic          word_last_o, word_valid_o, overflow_o, busy_o;
`ifdef ALN_STATS_EN
  logic [15:0]   sym_count_o;
`endif

  typedef struct packed {
    logic          last;
    logic [NW-1:0] nsym;
    logic [WW-1:0] data;
  } ent_t;

  ent_t          exp_q[$];
  ent_t          pop_log[$];
  int            checks = 0;
  int            errors = 0;
  logic [WW-1:0] m_word;
  int            m_cnt;
  bit            m_ovf;

  tb_align_collector #(.BP_WIDTH(BP), .WORD_WIDTH(WW), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset_i         (reset_i),
    .tb_valid        (tb_valid),
    .alignment_out   (alignment_out),
    .alignment_valid (alignment_valid),
    .done            (done),
    .word_o          (word_o),
    .word_nsym_o     (word_nsym_o),
    .word_last_o     (word_last_o),
    .word_valid_o    (word_valid_o),
    .word_ready_i    (word_ready_i),
    .overflow_o      (overflow_o),
    .busy_o          (busy_o)
`ifdef ALN_STATS_EN
    ,
    .sym_count_o     (sym_count_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Reference model: words are the symbol stream cut into SPW-sized groups;
  // a full word is lost when DEPTH words are already waiting.
  function automatic void m_start();
    m_word = '0;
    m_cnt  = 0;
    m_ovf  = 1'b0;
  endfunction

  function automatic void m_sym(input logic [BP-1:0] s);
    m_word = m_word | (WW'(s) << (m_cnt * BP));
    m_cnt++;
    if (m_cnt == SPW) begin
      if (exp_q.size() < DEPTH) exp_q.push_back('{1'b0, NW'(SPW), m_word});
      else m_ovf = 1'b1;
      m_word = '0;
      m_cnt  = 0;
    end
  endfunction

  function automatic void m_done();
    exp_q.push_back('{1'b1, NW'(m_cnt), m_word});
  endfunction

  always @(negedge clk) begin
    ent_t act;
    if (reset_i && word_valid_o && word_ready_i) begin
      act = '{word_last_o, word_nsym_o, word_o};
      pop_log.push_back(act);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0h required no word", act);
      end else begin
        check("pop_word", act, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    tb_valid = 1'b1;
    tick();
    m_start();
    pop_log.delete();
  endtask

  task automatic send(input logic [BP-1:0] s, input bit with_done);
    alignment_valid = 1'b1;
    alignment_out   = s;
    done            = with_done;
    m_sym(s);
    if (with_done) m_done();
    tick();
    alignment_valid = 1'b0;
    done            = 1'b0;
  endtask

  task automatic end_run();
    done = 1'b1;
    m_done();
    tick();
    done     = 1'b0;
    tb_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_o && n < 300) begin
      tick();
      n++;
    end
    tick();
    check(name, {63'd0, busy_o}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #2 reset_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {63'd0, word_valid_o}, 64'd0);
    check("rst_word", {32'd0, word_o}, 64'd0);
    check("rst_nsym", {59'd0, word_nsym_o}, 64'd0);
    check("rst_last", {63'd0, word_last_o}, 64'd0);
    check("rst_overflow", {63'd0, overflow_o}, 64'd0);
    check("rst_busy", {63'd0, busy_o}, 64'd0);
`ifdef ALN_STATS_EN
    check("rst_symcount", {48'd0, sym_count_o}, 64'd0);
`endif
    reset_i = 1'b1;
    tick();

    // Basic run
    word_ready_i = 1'b1;
    start_run();
    for (int i = 0; i < 16; i++) send(BP'(i % 4), 1'b0);
    end_run();
    wait_idle("basic_idle");
    check("basic_npop", pop_log.size(), 64'd2);
    if (pop_log.size() >= 2) begin
      check("basic_word", pop_log[0], {1'b0, 5'd16, 32'hE4E4E4E4});
      check("basic_term", pop_log[1], {1'b1, 5'd0, 32'h0});
    end

    // Partial word
    start_run();
    for (int i = 0; i < 5; i++) send(2'b11, 1'b0);
    end_run();
    wait_idle("partial_idle");
    check("partial_npop", pop_log.size(), 64'd1);
    if (pop_log.size() >= 1) check("partial_word", pop_log[0], {1'b1, 5'd5, 32'h000003FF});

    // Done arrives with the word-completing symbol
    start_run();
    for (int i = 0; i < 15; i++) send(BP'(i % 4), 1'b0);
    send(2'd3, 1'b1);
    tb_valid = 1'b0;
    wait_idle("coinc_idle");
    check("coinc_npop", pop_log.size(), 64'd2);
    if (pop_log.size() >= 2) begin
      check("coinc_word", pop_log[0], {1'b0, 5'd16, 32'hE4E4E4E4});
      check("coinc_term", pop_log[1], {1'b1, 5'd0, 32'h0});
    end

    // Overflow: reader stalled for five full words
    word_ready_i = 1'b0;
    start_run();
    for (int i = 0; i < 80; i++) send(BP'((i + i / 16) % 4), 1'b0);
    end_run();
    repeat (5) tick();
    check("ovf_flag", {63'd0, overflow_o}, 64'd1);
    check("ovf_model", {63'd0, overflow_o}, {63'd0, m_ovf});
    check("ovf_busy_flush", {63'd0, busy_o}, 64'd1);
    check("ovf_head_valid", {63'd0, word_valid_o}, 64'd1);
    check("ovf_head_not_term", {63'd0, word_last_o}, 64'd0);
    word_ready_i = 1'b1;
    wait_idle("ovf_idle");
    check("ovf_npop", pop_log.size(), 64'd5);
    if (pop_log.size() >= 5) begin
      check("ovf_word2", pop_log[1], {1'b0, 5'd16, 32'h39393939});
      check("ovf_term", pop_log[4], {1'b1, 5'd0, 32'h0});
    end
    check("ovf_sticky", {63'd0, overflow_o}, 64'd1);

    // Reset in the middle of a run
    word_ready_i = 1'b0;
    start_run();
    check("ovf_cleared", {63'd0, overflow_o}, 64'd0);
    for (int i = 0; i < 20; i++) send(2'b01, 1'b0);
    tick();
    check("mid_valid_before", {63'd0, word_valid_o}, 64'd1);
    tb_valid = 1'b0;
    reset_i  = 1'b0;
    #1;
    check("mid_valid_rst", {63'd0, word_valid_o}, 64'd0);
    check("mid_busy_rst", {63'd0, busy_o}, 64'd0);
    exp_q.delete();
    repeat (2) tick();
    reset_i = 1'b1;
    tick();
    word_ready_i = 1'b1;
    start_run();
`ifdef ALN_STATS_EN
    check("mid_symcount_clean", {48'd0, sym_count_o}, 64'd0);
`endif
    for (int i = 0; i < 3; i++) send(2'b10, 1'b0);
    end_run();
    wait_idle("mid_idle");
    check("mid_npop", pop_log.size(), 64'd1);
    if (pop_log.size() >= 1) check("mid_word", pop_log[0], {1'b1, 5'd3, 32'h0000002A});

    // 37-symbol run with the reader always ready
    start_run();
    for (int i = 0; i < 37; i++) send(BP'(i % 4), 1'b0);
    end_run();
`ifdef ALN_STATS_EN
    check("stats_count", {48'd0, sym_count_o}, 64'd37);
`endif
    wait_idle("stats_idle");
    check("stats_overflow", {63'd0, overflow_o}, 64'd0);
    check("stats_npop", pop_log.size(), 64'd3);
    if (pop_log.size() >= 3) check("stats_term", pop_log[2], {1'b1, 5'd5, 32'h000000E4});

    check("exp_drained", exp_q.size(), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
